// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: command codes and protocol states.
package spi_target_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one SPI pin, with a previous-value flop for edge detection.
module spi_sync #(
  parameter int SYNC = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC-1:0] r_chain;
  logic            r_prev;

  // Resetting to 0 means a select already held low across reset never shows up as a fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC-2:0], i_d};
      r_prev  <= r_chain[SYNC-1];
    end
  end

  assign o_level = r_chain[SYNC-1];
  assign o_rise  = r_chain[SYNC-1] & ~r_prev;
  assign o_fall  = ~r_chain[SYNC-1] & r_prev;

endmodule

// File: rtl/spi_target.sv
// SPI target (CPHA=0, CPOL latched at select) fronting a byte-addressed register file.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int AW   = 4,
  parameter int SYNC = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SCK,
  input  logic          MOSI,
  input  logic          nSS,
  output logic          MISO,
  output logic          MISO_OE,
  input  logic [AW-1:0] LADDR,
  output logic [7:0]    LDATA,
  output logic          WSTB,
  output logic [AW-1:0] WADDR,
  output logic [7:0]    WDATA,
  output logic          BUSY
);

  logic w_sckLvl, w_sckRise, w_sckFall;
  logic w_mosiLvl, w_mosiRise, w_mosiFall;
  logic w_nssLvl, w_nssRise, w_nssFall;
  logic w_unused;

  spi_sync #(.SYNC(SYNC)) u_syncSck (
    .CLK(CLK), .RST(RST), .i_d(SCK),
    .o_level(w_sckLvl), .o_rise(w_sckRise), .o_fall(w_sckFall)
  );

  spi_sync #(.SYNC(SYNC)) u_syncMosi (
    .CLK(CLK), .RST(RST), .i_d(MOSI),
    .o_level(w_mosiLvl), .o_rise(w_mosiRise), .o_fall(w_mosiFall)
  );

  spi_sync #(.SYNC(SYNC)) u_syncNss (
    .CLK(CLK), .RST(RST), .i_d(nSS),
    .o_level(w_nssLvl), .o_rise(w_nssRise), .o_fall(w_nssFall)
  );

  assign w_unused = w_mosiRise | w_mosiFall | w_nssLvl;

  state_t        r_state;
  logic          r_cpol;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_rxShift;
  logic [7:0]    r_txShift;
  logic [AW-1:0] r_ptr;
  logic          r_isWrite;
  logic          r_miso;
  logic          r_wstb;
  logic [AW-1:0] r_waddr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_mem [2**AW];

  logic       w_lead, w_trail;
  logic [7:0] w_rxByte;
  logic [7:0] w_rdByte;

  assign w_lead   = r_cpol ? w_sckFall : w_sckRise;
  assign w_trail  = r_cpol ? w_sckRise : w_sckFall;
  assign w_rxByte = {r_rxShift[6:0], w_mosiLvl};
  assign w_rdByte = r_mem[r_ptr];

  // Deselect is checked first so it overrides any SCK edge seen in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cpol    <= 1'b0;
      r_bitCnt  <= '0;
      r_rxShift <= '0;
      r_txShift <= '0;
      r_ptr     <= '0;
      r_isWrite <= 1'b0;
      r_miso    <= 1'b1;
      r_wstb    <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_wstb <= 1'b0;
      if (w_nssRise) begin
        r_state  <= ST_IDLE;
        r_bitCnt <= '0;
        r_miso   <= 1'b1;
      end else if (w_nssFall && r_state == ST_IDLE) begin
        r_state  <= ST_CMD;
        r_cpol   <= w_sckLvl;
        r_bitCnt <= '0;
      end else if (r_state != ST_IDLE && r_state != ST_IGNORE) begin
        if (w_lead) begin
          r_rxShift <= w_rxByte;
          r_bitCnt  <= r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            case (r_state)
              ST_CMD: begin
                if (w_rxByte == CMD_WRITE) begin
                  r_isWrite <= 1'b1;
                  r_state   <= ST_ADDR;
                end else if (w_rxByte == CMD_READ) begin
                  r_isWrite <= 1'b0;
                  r_state   <= ST_ADDR;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
              ST_ADDR: begin
                r_ptr   <= w_rxByte[AW-1:0];
                r_state <= r_isWrite ? ST_WDATA : ST_RDATA;
                r_miso  <= 1'b1;
              end
              ST_WDATA: begin
                r_wstb  <= 1'b1;
                r_waddr <= r_ptr;
                r_wdata <= w_rxByte;
                r_ptr   <= r_ptr + AW'(1);
              end
              default: ;
            endcase
          end
        end else if (w_trail && r_state == ST_RDATA) begin
          // A zero bit count marks a byte boundary, so fetch the next register.
          if (r_bitCnt == 3'd0) begin
            r_miso    <= w_rdByte[7];
            r_txShift <= {w_rdByte[6:0], 1'b0};
            r_ptr     <= r_ptr + AW'(1);
          end else begin
            r_miso    <= r_txShift[7];
            r_txShift <= {r_txShift[6:0], 1'b0};
          end
        end
      end
    end
  end

  // Commit lands one cycle after the strobe so a same-address local read sees old then new.
  always_ff @(posedge CLK) begin
    if (r_wstb) r_mem[r_waddr] <= r_wdata;
  end

  assign LDATA   = r_mem[LADDR];
  assign MISO    = (r_state == ST_RDATA) ? r_miso : 1'b1;
  assign MISO_OE = (r_state != ST_IDLE);
  assign BUSY    = (r_state != ST_IDLE);
  assign WSTB    = r_wstb;
  assign WADDR   = r_waddr;
  assign WDATA   = r_wdata;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-banged SPI master plus a write-strobe scoreboard.
module tb_spi_target;

  localparam int AW   = 4;
  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          SCK, MOSI, nSS;
  logic          MISO, MISO_OE;
  logic [AW-1:0] LADDR;
  logic [7:0]    LDATA;
  logic          WSTB;
  logic [AW-1:0] WADDR;
  logic [7:0]    WDATA;
  logic          BUSY;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [AW+7:0] expQ[$];
  logic [7:0]    txBuf[8];
  logic [7:0]    rxBuf[8];
  logic          cpolCur;

  spi_target #(.AW(AW), .SYNC(SYNC)) dut (
    .CLK(CLK), .RST(RST), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
    .MISO(MISO), .MISO_OE(MISO_OE), .LADDR(LADDR), .LDATA(LDATA),
    .WSTB(WSTB), .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (WSTB === 1'b1) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL wstbUnexpected: got addr %h data %h, expected no strobe", WADDR, WDATA);
      end else begin
        checkOutput("wstb", {20'h0, WADDR, WDATA}, {20'h0, expQ.pop_front()});
      end
    end
  end

  task automatic halfWait();
    repeat (HALF) @(negedge CLK);
  endtask

  task automatic selectTarget(input logic cpol);
    cpolCur = cpol;
    SCK = cpol;
    halfWait();
    nSS = 1'b0;
    halfWait();
  endtask

  task automatic deselectTarget();
    halfWait();
    nSS = 1'b1;
    halfWait();
    halfWait();
  endtask

  task automatic spiByte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      halfWait();
      SCK = ~cpolCur;
      rx = {rx[6:0], MISO};
      halfWait();
      SCK = cpolCur;
    end
  endtask

  task automatic applyStimulus(input logic cpol, input int n);
    selectTarget(cpol);
    checkOutput("busySel", {31'h0, BUSY}, 32'h1);
    for (int i = 0; i < n; i++) spiByte(txBuf[i], 8, rxBuf[i]);
    deselectTarget();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: got no finish, expected finish within 1ms");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] rx;
    RST = 1'b1; nSS = 1'b1; SCK = 1'b0; MOSI = 1'b0; LADDR = '0; cpolCur = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rstMiso",   {31'h0, MISO},    32'h1);
    checkOutput("rstMisoOe", {31'h0, MISO_OE}, 32'h0);
    checkOutput("rstWstb",   {31'h0, WSTB},    32'h0);
    checkOutput("rstWaddr",  {28'h0, WADDR},   32'h0);
    checkOutput("rstWdata",  {24'h0, WDATA},   32'h0);
    checkOutput("rstBusy",   {31'h0, BUSY},    32'h0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // CPOL=0 write of two bytes starting at 5
    txBuf[0] = 8'h02; txBuf[1] = 8'h05; txBuf[2] = 8'hA5; txBuf[3] = 8'h3C;
    expQ.push_back({4'h5, 8'hA5});
    expQ.push_back({4'h6, 8'h3C});
    applyStimulus(1'b0, 4);
    checkOutput("oeAfterWrite", {31'h0, MISO_OE}, 32'h0);
    LADDR = 4'h6; @(negedge CLK);
    checkOutput("ldata6", {24'h0, LDATA}, 32'h3C);

    // CPOL=1 read back
    txBuf[0] = 8'h03; txBuf[1] = 8'h05; txBuf[2] = 8'h00; txBuf[3] = 8'h00;
    applyStimulus(1'b1, 4);
    checkOutput("readCmdMiso", {24'h0, rxBuf[0]}, 32'hFF);
    checkOutput("readA5",      {24'h0, rxBuf[2]}, 32'hA5);
    checkOutput("read3C",      {24'h0, rxBuf[3]}, 32'h3C);

    // Pointer wrap and ignored upper address bits
    txBuf[0] = 8'h02; txBuf[1] = 8'h0F; txBuf[2] = 8'h11; txBuf[3] = 8'h22;
    expQ.push_back({4'hF, 8'h11});
    expQ.push_back({4'h0, 8'h22});
    applyStimulus(1'b0, 4);
    LADDR = 4'h0; @(negedge CLK);
    checkOutput("ldata0Wrap", {24'h0, LDATA}, 32'h22);
    txBuf[0] = 8'h03; txBuf[1] = 8'h1F; txBuf[2] = 8'h00;
    applyStimulus(1'b0, 3);
    checkOutput("readWrap11", {24'h0, rxBuf[2]}, 32'h11);

    // Abort a partial data byte
    txBuf[0] = 8'h02; txBuf[1] = 8'h03; txBuf[2] = 8'h77;
    expQ.push_back({4'h3, 8'h77});
    applyStimulus(1'b0, 3);
    selectTarget(1'b0);
    spiByte(8'h02, 8, rx);
    spiByte(8'h03, 8, rx);
    spiByte(8'hFF, 5, rx);
    deselectTarget();
    checkOutput("abortOe", {31'h0, MISO_OE}, 32'h0);
    LADDR = 4'h3; @(negedge CLK);
    checkOutput("abortMem3", {24'h0, LDATA}, 32'h77);
    txBuf[0] = 8'h02; txBuf[1] = 8'h04; txBuf[2] = 8'h5A;
    expQ.push_back({4'h4, 8'h5A});
    applyStimulus(1'b0, 3);
    LADDR = 4'h4; @(negedge CLK);
    checkOutput("afterAbort4", {24'h0, LDATA}, 32'h5A);

    // Unknown command is ignored
    txBuf[0] = 8'h9F; txBuf[1] = 8'h02; txBuf[2] = 8'h00; txBuf[3] = 8'hAA;
    applyStimulus(1'b0, 4);
    for (int i = 1; i < 4; i++) checkOutput("ignoreMiso", {24'h0, rxBuf[i]}, 32'hFF);

    // Reset in the middle of a read
    selectTarget(1'b0);
    spiByte(8'h03, 8, rx);
    spiByte(8'h05, 8, rx);
    spiByte(8'h00, 3, rx);
    RST = 1'b1;
    #1;
    checkOutput("rstMidOe",   {31'h0, MISO_OE}, 32'h0);
    checkOutput("rstMidMiso", {31'h0, MISO},    32'h1);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    SCK = 1'b0;
    halfWait();
    // nSS is still low: a full write byte pattern must be ignored
    spiByte(8'h02, 8, rx);
    spiByte(8'h01, 8, rx);
    spiByte(8'hEE, 8, rx);
    checkOutput("staleSelOe",   {31'h0, MISO_OE}, 32'h0);
    checkOutput("staleSelBusy", {31'h0, BUSY},    32'h0);
    deselectTarget();
    txBuf[0] = 8'h03; txBuf[1] = 8'h05; txBuf[2] = 8'h00;
    applyStimulus(1'b0, 3);
    checkOutput("readAfterRst", {24'h0, rxBuf[2]}, 32'hA5);

    repeat (10) @(negedge CLK);
    checkOutput("wstbPending", expQ.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
